// File: rtl/rw_task_sched.sv
// rw_task_sched: round-robin two-client scheduler sharing one rw_fsm engine, with retry, timeout and one response per request
module rw_task_sched #(
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = 1023,
  parameter int CW        = 10
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req0_valid,
  input  logic [1:0]  req0_tsk,
  input  logic [15:0] req0_page,
  input  logic [63:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [1:0]  req1_tsk,
  input  logic [15:0] req1_page,
  input  logic [63:0] req1_data,
  output logic        req1_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic        rsp_success,
  output logic [1:0]  rsp_retries,
  output logic [63:0] rsp_data,
  output logic        rw_rst_b,
  output logic [1:0]  rw_tsk,
  output logic [15:0] rw_mempage,
  output logic [63:0] rw_data_in,
  input  logic        rw_task_done,
  input  logic        rw_task_success,
  input  logic [63:0] rw_data_to_tb
);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_t;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [7:0]    MAX_R   = 8'(MAX_RETRY);
  state_t        r_state;
  logic          r_last_grant;
  logic          r_id;
  logic          r_success;
  logic [1:0]    r_tsk;
  logic [15:0]   r_page;
  logic [63:0]   r_data;
  logic [63:0]   r_rsp_data;
  logic [7:0]    r_retry;
  logic [CW-1:0] r_cnt;
  logic          w_gnt;
  logic          w_acc;
  logic          w_fail;
  logic [1:0]    w_tsk;
  assign w_gnt       = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  assign w_acc       = (r_state == IDLE) && (req0_valid || req1_valid);
  assign w_tsk       = w_gnt ? req1_tsk : req0_tsk;
  assign w_fail      = rw_task_done ? !rw_task_success : (r_cnt == TO_LAST);
  assign req0_ready  = w_acc && !w_gnt;
  assign req1_ready  = w_acc && w_gnt;
  assign rsp_valid   = r_state == RESP;
  assign rsp_id      = r_id;
  assign rsp_success = r_success;
  assign rsp_retries = (r_retry > 8'd3) ? 2'd3 : r_retry[1:0];
  assign rsp_data    = r_rsp_data;
  assign rw_rst_b    = rst_b && (r_state != CLEAR);
  assign rw_tsk      = (r_state == RUN) ? r_tsk : 2'b00;
  assign rw_mempage  = r_page;
  assign rw_data_in  = r_data;
  // Scheduler FSM: accept, re-arm engine, run with timeout/retry, hold response until consumed
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_success    <= 1'b0;
      r_tsk        <= 2'b00;
      r_page       <= '0;
      r_data       <= '0;
      r_rsp_data   <= '0;
      r_retry      <= '0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_id         <= w_gnt;
          r_last_grant <= w_gnt;
          r_tsk        <= w_tsk;
          r_page       <= w_gnt ? req1_page : req0_page;
          r_data       <= w_gnt ? req1_data : req0_data;
          r_retry      <= '0;
          r_success    <= 1'b0;
          r_rsp_data   <= '0;
          r_state      <= (^w_tsk) ? CLEAR : RESP;
        end
        CLEAR: begin
          r_cnt   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (rw_task_done && rw_task_success) begin
            r_success  <= 1'b1;
            r_rsp_data <= (r_tsk == 2'b01) ? rw_data_to_tb : 64'd0;
            r_state    <= RESP;
          end else if (w_fail) begin
            r_retry <= (r_retry < MAX_R) ? r_retry + 8'd1 : r_retry;
            r_state <= (r_retry < MAX_R) ? CLEAR : RESP;
          end
        end
        RESP: if (rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rw_task_sched.sv
// tb_rw_task_sched: scoreboard bench for rw_task_sched with a behavioural rw_fsm engine model
module tb_rw_task_sched;
  logic        clk = 0;
  logic        rst_b = 0;
  logic        req0_valid = 0, req1_valid = 0;
  logic [1:0]  req0_tsk = 0, req1_tsk = 0;
  logic [15:0] req0_page = 0, req1_page = 0;
  logic [63:0] req0_data = 0, req1_data = 0;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_ready = 0, rsp_id, rsp_success;
  logic [1:0]  rsp_retries;
  logic [63:0] rsp_data;
  logic        rw_rst_b;
  logic [1:0]  rw_tsk;
  logic [15:0] rw_mempage;
  logic [63:0] rw_data_in;
  logic        rw_task_done = 0, rw_task_success = 0;
  logic [63:0] rw_data_to_tb;
  int n_checks = 0, n_fail = 0;
  logic [67:0] sb[$];
  int eng_delay = 6, eng_att = 0, eng_ok_from = 0, run_cyc = 0;
  logic [63:0] eng_rdata = 0;
  int n_clear = 0, run_len = 0, run_bad = 0;
  int run_lens[$];
  logic [1:0]  mon_tsk = 0;
  logic [15:0] mon_page = 0;
  logic [63:0] mon_data = 0;

  assign rw_data_to_tb = eng_rdata;
  always #5 clk = ~clk;

  rw_task_sched #(.MAX_RETRY(2), .TIMEOUT(8), .CW(4)) dut (
    .clk(clk), .rst_b(rst_b),
    .req0_valid(req0_valid), .req0_tsk(req0_tsk), .req0_page(req0_page), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_tsk(req1_tsk), .req1_page(req1_page), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_success(rsp_success),
    .rsp_retries(rsp_retries), .rsp_data(rsp_data),
    .rw_rst_b(rw_rst_b), .rw_tsk(rw_tsk), .rw_mempage(rw_mempage), .rw_data_in(rw_data_in),
    .rw_task_done(rw_task_done), .rw_task_success(rw_task_success), .rw_data_to_tb(rw_data_to_tb)
  );

  // Engine model: signals done after eng_delay RUN cycles, failing until eng_ok_from attempts have been made
  initial forever begin
    @(negedge clk);
    if (!rw_rst_b || rw_tsk == 2'b00) begin
      run_cyc = 0; rw_task_done = 0; rw_task_success = 0;
    end else begin
      run_cyc++;
      if (eng_delay != 0 && run_cyc == eng_delay) begin
        rw_task_done = 1; rw_task_success = (eng_att >= eng_ok_from); eng_att++;
      end else begin
        rw_task_done = 0; rw_task_success = 0;
      end
    end
  end

  // Monitor: counts engine re-arm pulses, RUN lengths and engine-drive mismatches during RUN
  initial forever begin
    @(negedge clk);
    if (rst_b && !rw_rst_b) n_clear++;
    if (rw_tsk != 2'b00) begin
      run_len++;
      if (rw_tsk !== mon_tsk || rw_mempage !== mon_page || rw_data_in !== mon_data) run_bad++;
    end else if (run_len != 0) begin
      run_lens.push_back(run_len); run_len = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input bit id, input logic [1:0] tsk, input logic [15:0] page, input logic [63:0] data, output bit ok);
    ok = 0;
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    if (id) begin req1_valid = 1; req1_tsk = tsk; req1_page = page; req1_data = data; end
    else begin req0_valid = 1; req0_tsk = tsk; req0_page = page; req0_data = data; end
    for (int i = 0; i < 50; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic wait_rsp(output bit ok, output logic [67:0] v);
    ok = 0; v = '0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid === 1'b1) begin ok = 1; v = {rsp_id, rsp_success, rsp_retries, rsp_data}; break; end
      @(negedge clk);
    end
  endtask

  task automatic ack();
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    rst_b = 0;
    repeat (2) @(negedge clk);
    n_checks++; if (rw_rst_b !== 1'b0) begin n_fail++; $display("FAIL reset_rw_rst_b: got %b expected 0", rw_rst_b); end
    n_checks++; if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin n_fail++; $display("FAIL reset_handshake: got %b expected 000", {rsp_valid, req0_ready, req1_ready}); end
    n_checks++; if ({rsp_id, rsp_success, rsp_retries, rsp_data} !== 68'd0) begin n_fail++; $display("FAIL reset_rsp: got %h expected 0", {rsp_id, rsp_success, rsp_retries, rsp_data}); end
    n_checks++; if ({rw_tsk, rw_mempage, rw_data_in} !== 82'd0) begin n_fail++; $display("FAIL reset_engine_drive: got %h expected 0", {rw_tsk, rw_mempage, rw_data_in}); end
    rst_b = 1;
    @(negedge clk);
    n_checks++; if (rw_rst_b !== 1'b1) begin n_fail++; $display("FAIL release_rw_rst_b: got %b expected 1", rw_rst_b); end
    req0_valid = 1; req1_valid = 1;
    #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL first_grant: got %b expected 10", {req0_ready, req1_ready}); end
    req0_valid = 0; req1_valid = 0;
    #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL idle_no_ready: got %b expected 00", {req0_ready, req1_ready}); end
  endtask

  task automatic test_read();
    bit ok; logic [67:0] v, e; int c0;
    eng_delay = 6; eng_ok_from = eng_att; eng_rdata = 64'hDEAD_BEEF_0123_4567;
    mon_tsk = 2'b01; mon_page = 16'h00A5; mon_data = 64'd0;
    c0 = n_clear;
    sb.push_back({1'b0, 1'b1, 2'd0, 64'hDEAD_BEEF_0123_4567});
    send(0, 2'b01, 16'h00A5, 64'd0, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL read_accept: got %b expected 1", ok); end
    n_checks++; if ({rw_rst_b, rw_tsk} !== 3'b000) begin n_fail++; $display("FAIL read_clear_cycle: got %b expected 000", {rw_rst_b, rw_tsk}); end
    @(negedge clk);
    n_checks++; if ({rw_rst_b, rw_tsk, rw_mempage} !== {1'b1, 2'b01, 16'h00A5}) begin n_fail++; $display("FAIL read_run_drive: got %h expected %h", {rw_rst_b, rw_tsk, rw_mempage}, {1'b1, 2'b01, 16'h00A5}); end
    wait_rsp(ok, v);
    n_checks++;
    if (!ok || sb.size() == 0) begin n_fail++; $display("FAIL read_rsp: got no response expected one"); end
    else begin e = sb.pop_front(); if (v !== e) begin n_fail++; $display("FAIL read_rsp: got %h expected %h", v, e); end end
    ack();
    n_checks++; if (n_clear - c0 !== 1) begin n_fail++; $display("FAIL read_clear_pulses: got %0d expected 1", n_clear - c0); end
  endtask

  task automatic test_write();
    bit ok; logic [67:0] v, e; int b0, r0;
    eng_delay = 5; eng_ok_from = eng_att; eng_rdata = 64'hFFFF_0000_FFFF_0000;
    mon_tsk = 2'b10; mon_page = 16'h0300; mon_data = 64'h1122_3344_5566_7788;
    b0 = run_bad; r0 = run_lens.size();
    sb.push_back({1'b1, 1'b1, 2'd0, 64'd0});
    send(1, 2'b10, 16'h0300, 64'h1122_3344_5566_7788, ok);
    wait_rsp(ok, v);
    n_checks++;
    if (!ok || sb.size() == 0) begin n_fail++; $display("FAIL write_rsp: got no response expected one"); end
    else begin e = sb.pop_front(); if (v !== e) begin n_fail++; $display("FAIL write_rsp: got %h expected %h", v, e); end end
    ack();
    n_checks++; if (run_bad - b0 !== 0 || run_lens.size() - r0 !== 1) begin n_fail++; $display("FAIL write_run_stable: got %0d bad cycles over %0d runs expected 0 over 1", run_bad - b0, run_lens.size() - r0); end
  endtask

  task automatic test_back_to_back();
    logic [67:0] e, v; logic [3:0] grants; int ng, nr, pulses;
    eng_delay = 4; eng_ok_from = eng_att; eng_rdata = 64'h0BAD_F00D_0000_0001;
    grants = 0; ng = 0; nr = 0; pulses = 0;
    @(negedge clk);
    req0_tsk = 2'b01; req0_page = 16'h0001; req0_data = 64'd0;
    req1_tsk = 2'b10; req1_page = 16'h0002; req1_data = 64'h55;
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    for (int i = 0; i < 300 && nr < 4; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        pulses++;
        if (ng < 4) begin
          grants = {grants[2:0], req1_ready};
          sb.push_back(req1_ready ? {1'b1, 1'b1, 2'd0, 64'd0} : {1'b0, 1'b1, 2'd0, eng_rdata});
          ng++;
        end
      end
      if (rsp_valid) begin
        nr++;
        v = {rsp_id, rsp_success, rsp_retries, rsp_data};
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_rsp: got %h expected none", v); end
        else begin e = sb.pop_front(); if (v !== e) begin n_fail++; $display("FAIL b2b_rsp: got %h expected %h", v, e); end end
      end
      @(negedge clk);
      if (ng == 4) begin req0_valid = 0; req1_valid = 0; end
    end
    rsp_ready = 0;
    n_checks++; if (grants !== 4'b0101) begin n_fail++; $display("FAIL b2b_grants: got %b expected 0101", grants); end
    n_checks++; if (pulses !== 4 || nr !== 4) begin n_fail++; $display("FAIL b2b_counts: got %0d readys %0d responses expected 4 and 4", pulses, nr); end
  endtask

  task automatic test_retry(input int fails, input logic [67:0] exp, input string name);
    bit ok; logic [67:0] v, e; int c0;
    eng_delay = 3; eng_ok_from = eng_att + fails; eng_rdata = 64'h0000_1234_5678_9ABC;
    mon_tsk = 2'b01; mon_page = 16'h0007; mon_data = 64'd0;
    c0 = n_clear;
    sb.push_back(exp);
    send(0, 2'b01, 16'h0007, 64'd0, ok);
    wait_rsp(ok, v);
    n_checks++;
    if (!ok || sb.size() == 0) begin n_fail++; $display("FAIL %s_rsp: got no response expected one", name); end
    else begin e = sb.pop_front(); if (v !== e) begin n_fail++; $display("FAIL %s_rsp: got %h expected %h", name, v, e); end end
    ack();
    n_checks++; if (n_clear - c0 !== 3) begin n_fail++; $display("FAIL %s_clear_pulses: got %0d expected 3", name, n_clear - c0); end
  endtask

  task automatic test_timeout();
    bit ok, all8; logic [67:0] v, e; int r0;
    eng_delay = 0; eng_rdata = 64'h7777_7777_7777_7777;
    r0 = run_lens.size();
    sb.push_back({1'b1, 1'b0, 2'd2, 64'd0});
    send(1, 2'b10, 16'h0040, 64'h99, ok);
    wait_rsp(ok, v);
    n_checks++;
    if (!ok || sb.size() == 0) begin n_fail++; $display("FAIL timeout_rsp: got no response expected one"); end
    else begin e = sb.pop_front(); if (v !== e) begin n_fail++; $display("FAIL timeout_rsp: got %h expected %h", v, e); end end
    ack();
    all8 = 1;
    for (int i = r0; i < run_lens.size(); i++) if (run_lens[i] != 8) all8 = 0;
    n_checks++; if (run_lens.size() - r0 !== 3 || all8 !== 1'b1) begin n_fail++; $display("FAIL timeout_attempts: got %0d attempts all8=%b expected 3 attempts all8=1", run_lens.size() - r0, all8); end
  endtask

  task automatic test_illegal();
    bit ok; logic [67:0] v, e; int c0;
    logic [1:0] tsks [2];
    tsks[0] = 2'b00; tsks[1] = 2'b11;
    for (int k = 0; k < 2; k++) begin
      c0 = n_clear;
      sb.push_back({k[0], 1'b0, 2'd0, 64'd0});
      send(k[0], tsks[k], 16'h0F0F, 64'hABCD, ok);
      n_checks++; if ({rsp_valid, rw_rst_b} !== 2'b11) begin n_fail++; $display("FAIL illegal_immediate_%0d: got %b expected 11", k, {rsp_valid, rw_rst_b}); end
      wait_rsp(ok, v);
      n_checks++;
      if (!ok || sb.size() == 0) begin n_fail++; $display("FAIL illegal_rsp_%0d: got no response expected one", k); end
      else begin e = sb.pop_front(); if (v !== e) begin n_fail++; $display("FAIL illegal_rsp_%0d: got %h expected %h", k, v, e); end end
      ack();
      n_checks++; if (n_clear - c0 !== 0) begin n_fail++; $display("FAIL illegal_clear_%0d: got %0d expected 0", k, n_clear - c0); end
    end
  endtask

  task automatic test_backpressure();
    bit ok, stable; logic [67:0] v, e;
    eng_delay = 2; eng_ok_from = eng_att; eng_rdata = 64'h0000_0000_CAFE_F00D;
    sb.push_back({1'b0, 1'b1, 2'd0, 64'h0000_0000_CAFE_F00D});
    send(0, 2'b01, 16'h0011, 64'd0, ok);
    wait_rsp(ok, v);
    n_checks++;
    if (!ok || sb.size() == 0) begin n_fail++; $display("FAIL bp_rsp: got no response expected one"); end
    else begin e = sb.pop_front(); if (v !== e) begin n_fail++; $display("FAIL bp_rsp: got %h expected %h", v, e); end end
    stable = 1;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || {rsp_id, rsp_success, rsp_retries, rsp_data} !== v) stable = 0;
    end
    n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %b expected 1", stable); end
    ack();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_consumed: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_mid_reset();
    bit ok, seen;
    eng_delay = 0;
    send(0, 2'b01, 16'h0022, 64'd0, ok);
    repeat (3) @(negedge clk);
    n_checks++; if (rw_tsk !== 2'b01) begin n_fail++; $display("FAIL midrst_running: got %b expected 01", rw_tsk); end
    rst_b = 0;
    @(negedge clk);
    n_checks++; if ({rsp_valid, rw_rst_b, rw_tsk} !== 4'b0000) begin n_fail++; $display("FAIL midrst_abort: got %b expected 0000", {rsp_valid, rw_rst_b, rw_tsk}); end
    @(negedge clk);
    rst_b = 1;
    seen = 0;
    repeat (20) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1; end
    n_checks++; if (seen !== 1'b0 || rw_rst_b !== 1'b1) begin n_fail++; $display("FAIL midrst_no_rsp: got seen=%b rw_rst_b=%b expected 0 and 1", seen, rw_rst_b); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_retry(2, {1'b0, 1'b1, 2'd2, 64'h0000_1234_5678_9ABC}, "retry_ok");
    test_retry(3, {1'b0, 1'b0, 2'd2, 64'd0}, "retry_fail");
    test_timeout();
    test_illegal();
    test_backpressure();
    test_mid_reset();
    n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
